// File: rtl/sparse_dot_sequencer_pkg.sv
// Shared types and constants for the sparse dot-product sequencer.
package sparse_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMP   = 3'd1,
        MUL   = 3'd2,
        ADD   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

    localparam logic [15:0] FP16_ZERO  = 16'h0000;
    localparam logic        FPU_OP_MUL = 1'b0;
    localparam logic        FPU_OP_ADD = 1'b1;

endpackage

// File: rtl/sparse_dot_sequencer_if.sv
// Stream (A, B) and fpu bus of the sparse dot-product sequencer.
// master = stream producer / fpu side, slave = sequencer side.
interface sparse_dot_sequencer_if #(parameter int IDX_W = 8);

    logic             a_valid, a_ready, a_last;
    logic [IDX_W-1:0] a_idx;
    logic [15:0]      a_val;
    logic             b_valid, b_ready, b_last;
    logic [IDX_W-1:0] b_idx;
    logic [15:0]      b_val;

    logic             fpu_clk_en, fpu_op;
    logic [15:0]      fpu_dataa, fpu_datab, fpu_result;
    logic             fpu_overflow, fpu_underflow, fpu_nan;

    modport master (
        output a_valid, a_idx, a_val, a_last, input a_ready,
        output b_valid, b_idx, b_val, b_last, input b_ready,
        input  fpu_clk_en, fpu_op, fpu_dataa, fpu_datab,
        output fpu_result, fpu_overflow, fpu_underflow, fpu_nan
    );

    modport slave (
        input  a_valid, a_idx, a_val, a_last, output a_ready,
        input  b_valid, b_idx, b_val, b_last, output b_ready,
        output fpu_clk_en, fpu_op, fpu_dataa, fpu_datab,
        input  fpu_result, fpu_overflow, fpu_underflow, fpu_nan
    );

endinterface

// File: rtl/sparse_dot_sequencer_timer.sv
// fpu_wait_timer: counts FPU_LAT cycles after each fpu op is issued and
// pulses expire during the cycle in which the fpu result is valid.
module fpu_wait_timer #(
    parameter int FPU_LAT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam int CW = $clog2(FPU_LAT + 1);

    logic [CW-1:0] cnt;

    // Load FPU_LAT on op entry, count down to zero and rest there.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= CW'(FPU_LAT);
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign expire = (cnt == CW'(1));

endmodule

// File: rtl/sparse_dot_sequencer.sv
// sparse_dot_sequencer: merge-joins two index-sorted sparse vectors and
// accumulates sum(a[i]*b[i]) on the shared fp16 fpu.
// Optional feature macro: SPARSE_PERF_CNT_EN (match_cnt / cycle_cnt outputs).
module sparse_dot_sequencer
    import sparse_pkg::*;
#(
    parameter int IDX_W   = 8,
    parameter int FPU_LAT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    sparse_dot_sequencer_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           result,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  nan
`ifdef SPARSE_PERF_CNT_EN
    ,
    output logic [IDX_W-1:0]      match_cnt,
    output logic [15:0]           cycle_cnt
`endif
);

    seq_state_t       state, state_nxt;
    logic             a_end, b_end;
    logic             a_rdy, b_rdy;
    logic             tmr_load, expire;
    logic [15:0]      a_lat, b_lat, prod, acc;
    logic [IDX_W-1:0] a_idx, b_idx;

    assign a_idx = bus.a_idx;
    assign b_idx = bus.b_idx;

    fpu_wait_timer #(.FPU_LAT(FPU_LAT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .expire (expire)
    );

    // Next state, stream readies and timer load.
    always_comb begin
        state_nxt = state;
        a_rdy     = 1'b0;
        b_rdy     = 1'b0;
        tmr_load  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = CMP;
            CMP: begin
                if (a_end && b_end)
                    state_nxt = DONE;
                else if (a_end || b_end)
                    state_nxt = DRAIN;
                else if (bus.a_valid && bus.b_valid) begin
                    if (a_idx == b_idx) begin
                        a_rdy     = 1'b1;
                        b_rdy     = 1'b1;
                        tmr_load  = 1'b1;
                        state_nxt = MUL;
                    end else if (a_idx < b_idx)
                        a_rdy = 1'b1;
                    else
                        b_rdy = 1'b1;
                end
            end
            MUL: if (expire) begin
                tmr_load  = 1'b1;
                state_nxt = ADD;
            end
            ADD:   if (expire) state_nxt = CMP;
            DRAIN: begin
                // Only the unfinished stream is drained; its entries are dropped.
                a_rdy = !a_end && bus.a_valid;
                b_rdy = !b_end && bus.b_valid;
                if ((a_rdy && bus.a_last) || (b_rdy && bus.b_last))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.a_ready = a_rdy;
    assign bus.b_ready = b_rdy;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    // fpu drive: operands held through the whole op, zero when idle.
    always_comb begin
        bus.fpu_clk_en = 1'b0;
        bus.fpu_op     = FPU_OP_MUL;
        bus.fpu_dataa  = FP16_ZERO;
        bus.fpu_datab  = FP16_ZERO;
        if (state == MUL) begin
            bus.fpu_clk_en = 1'b1;
            bus.fpu_dataa  = a_lat;
            bus.fpu_datab  = b_lat;
        end else if (state == ADD) begin
            bus.fpu_clk_en = 1'b1;
            bus.fpu_op     = FPU_OP_ADD;
            bus.fpu_dataa  = acc;
            bus.fpu_datab  = prod;
        end
    end

    // Job state: end markers, operand latches, accumulator and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_end     <= 1'b0;
            b_end     <= 1'b0;
            a_lat     <= FP16_ZERO;
            b_lat     <= FP16_ZERO;
            prod      <= FP16_ZERO;
            acc       <= FP16_ZERO;
            result    <= FP16_ZERO;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            nan       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                acc       <= FP16_ZERO;
                a_end     <= 1'b0;
                b_end     <= 1'b0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
                nan       <= 1'b0;
            end
            if (a_rdy && bus.a_last) a_end <= 1'b1;
            if (b_rdy && bus.b_last) b_end <= 1'b1;
            if (state == CMP && a_rdy && b_rdy) begin
                a_lat <= bus.a_val;
                b_lat <= bus.b_val;
            end
            if (expire && (state == MUL || state == ADD)) begin
                if (state == MUL) prod <= bus.fpu_result;
                else              acc  <= bus.fpu_result;
                overflow  <= overflow  | bus.fpu_overflow;
                underflow <= underflow | bus.fpu_underflow;
                nan       <= nan       | bus.fpu_nan;
            end
            // Loaded on entry to DONE so the value is already final while done is high.
            if (state_nxt == DONE && state != DONE)
                result <= acc;
        end
    end

`ifdef SPARSE_PERF_CNT_EN
    // Match and cycle counters: cleared on start, frozen once back in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_cnt <= '0;
            cycle_cnt <= '0;
        end else if (state == IDLE && start) begin
            match_cnt <= '0;
            cycle_cnt <= '0;
        end else begin
            if (state == CMP && a_rdy && b_rdy)
                match_cnt <= match_cnt + {{(IDX_W-1){1'b0}}, 1'b1};
            if (state != IDLE && cycle_cnt != 16'hFFFF)
                cycle_cnt <= cycle_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sparse_dot_sequencer.sv
// Self-checking bench for sparse_dot_sequencer: random sparse vectors and
// valid gaps, an fp16 fpu model with real latency, and a reference dot product.
module tb_sparse_dot_sequencer;

    localparam int IDX_W   = 8;
    localparam int FPU_LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, overflow, underflow, nan;
    logic [15:0] result;
`ifdef SPARSE_PERF_CNT_EN
    logic [IDX_W-1:0] match_cnt;
    logic [15:0]      cycle_cnt;
`endif

    sparse_dot_sequencer_if #(.IDX_W(IDX_W)) bus();

    sparse_dot_sequencer #(.IDX_W(IDX_W), .FPU_LAT(FPU_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .nan       (nan)
`ifdef SPARSE_PERF_CNT_EN
        ,
        .match_cnt (match_cnt),
        .cycle_cnt (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // ---------------- fp16 arithmetic via reals ----------------
    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e = int'(h[14:10]);
        int  f = int'(h[9:0]);
        if (e == 31)     m = 1.0e30;
        else if (e == 0) m = real'(f) * pow2(-24);
        else             m = real'(1024 + f) * pow2(e - 25);
        return h[15] ? -m : m;
    endfunction

    // returns {overflow, underflow, fp16}
    function automatic logic [17:0] r2h(input real r);
        logic s = (r < 0.0);
        real  a = s ? -r : r;
        int   e = 0;
        int   m;
        if (a == 0.0) return {2'b00, s, 15'd0};
        if (a >= 65520.0) return {2'b10, s, 5'h1F, 10'd0};
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > -14) begin a = a * 2.0; e--; end
        if (a < 1.0) begin
            m = $rtoi(a * 1024.0 + 0.5);
            if (m >= 1024) return {2'b00, s, 5'd1, 10'd0};
            return {2'b01, s, 5'd0, m[9:0]};
        end
        m = $rtoi((a - 1.0) * 1024.0 + 0.5);
        if (m >= 1024) begin m = 0; e++; end
        if (e > 15) return {2'b10, s, 5'h1F, 10'd0};
        return {2'b00, s, 5'(e + 15), m[9:0]};
    endfunction

    // returns {overflow, underflow, nan, fp16}
    function automatic logic [18:0] fpu_calc(input logic op, input logic [15:0] a, input logic [15:0] b);
        logic        an = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        logic        bn = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        real         x;
        logic [17:0] t;
        if (an || bn) return {3'b001, 16'h7E00};
        x = op ? (h2r(a) + h2r(b)) : (h2r(a) * h2r(b));
        t = r2h(x);
        return {t[17:16], 1'b0, t[15:0]};
    endfunction

    // ---------------- fpu model: FPU_LAT-cycle pipeline ----------------
    logic [19:0] fp1 = '0, fp2 = '0;
    always @(posedge clk) begin
        fp1 <= {bus.fpu_clk_en, fpu_calc(bus.fpu_op, bus.fpu_dataa, bus.fpu_datab)};
        fp2 <= fp1;
    end
    assign bus.fpu_result    = fp2[19] ? fp2[15:0] : 16'hBAD0;
    assign bus.fpu_overflow  = fp2[19] & fp2[18];
    assign bus.fpu_underflow = fp2[19] & fp2[17];
    assign bus.fpu_nan       = fp2[19] & fp2[16];

    // ---------------- job vectors and reference ----------------
    logic [7:0]  ai[$], bi[$];
    logic [15:0] av[$], bv[$];
    logic [15:0] vtab [8];

    function automatic logic [18:0] ref_dot();
        logic [15:0] acc = 16'h0000;
        logic [2:0]  fl  = 3'b000;
        logic [18:0] p, s;
        foreach (ai[i])
            foreach (bi[j])
                if (ai[i] == bi[j]) begin
                    p   = fpu_calc(1'b0, av[i], bv[j]);
                    s   = fpu_calc(1'b1, acc, p[15:0]);
                    acc = s[15:0];
                    fl  = fl | p[18:16] | s[18:16];
                end
        return {fl, acc};
    endfunction

    // ---------------- stream driver / monitor ----------------
    int          a_pos, b_pos, a_acc, b_acc, rdy_viol, en_cyc, done_cnt, gap_pct;
    bit          drv_en = 1'b0;
    bit          a_hs = 1'b0, b_hs = 1'b0;
    logic [15:0] res_cap;
    logic [2:0]  flg_cap;

    always begin
        @(negedge clk);
        if (a_hs) begin a_pos++; a_acc++; end
        if (b_hs) begin b_pos++; b_acc++; end
        if (drv_en && a_pos < ai.size() &&
            ((bus.a_valid && !a_hs) || $urandom_range(99) >= gap_pct)) begin
            bus.a_valid = 1'b1;
            bus.a_idx   = ai[a_pos];
            bus.a_val   = av[a_pos];
            bus.a_last  = (a_pos == ai.size() - 1);
        end else begin
            bus.a_valid = 1'b0;
            bus.a_idx   = 8'($urandom);
            bus.a_val   = 16'($urandom);
            bus.a_last  = 1'($urandom);
        end
        if (drv_en && b_pos < bi.size() &&
            ((bus.b_valid && !b_hs) || $urandom_range(99) >= gap_pct)) begin
            bus.b_valid = 1'b1;
            bus.b_idx   = bi[b_pos];
            bus.b_val   = bv[b_pos];
            bus.b_last  = (b_pos == bi.size() - 1);
        end else begin
            bus.b_valid = 1'b0;
            bus.b_idx   = 8'($urandom);
            bus.b_val   = 16'($urandom);
            bus.b_last  = 1'($urandom);
        end
        #1;
        a_hs = bus.a_valid && bus.a_ready;
        b_hs = bus.b_valid && bus.b_ready;
        if ((bus.a_ready && !bus.a_valid) || (bus.b_ready && !bus.b_valid)) rdy_viol++;
        if (bus.fpu_clk_en) en_cyc++;
        if (done) begin
            done_cnt++;
            res_cap = result;
            flg_cap = {overflow, underflow, nan};
        end
    end

    task automatic prep(input int gap);
        gap_pct  = gap;
        a_pos    = 0; b_pos = 0; a_acc = 0; b_acc = 0;
        a_hs     = 1'b0; b_hs = 1'b0;
        rdy_viol = 0; en_cyc = 0; done_cnt = 0;
        drv_en   = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_job(input string tag, input int gap);
        logic [18:0] exp;
        int          m = 0;
        int          bound = 0;
        exp = ref_dot();
        foreach (ai[i]) foreach (bi[j]) if (ai[i] == bi[j]) m++;
        prep(gap);
        while (done_cnt == 0 && bound < 3000) begin @(negedge clk); bound++; end
        repeat (3) @(negedge clk);
        #2;
        chk({tag, "_done"},  done_cnt, 1);
        chk({tag, "_res"},   res_cap, exp[15:0]);
        chk({tag, "_flags"}, flg_cap, exp[18:16]);
        chk({tag, "_hold"},  result, exp[15:0]);
        chk({tag, "_a_acc"}, a_acc, ai.size());
        chk({tag, "_b_acc"}, b_acc, bi.size());
        chk({tag, "_rdy"},   rdy_viol, 0);
        chk({tag, "_fpuen"}, en_cyc, 2 * FPU_LAT * m);
        chk({tag, "_busy"},  busy, 0);
        drv_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic gen_vec(output logic [7:0] qi[$], output logic [15:0] qv[$]);
        int         n = $urandom_range(1, 6);
        logic [7:0] k = 8'($urandom_range(0, 3));
        qi.delete(); qv.delete();
        for (int i = 0; i < n; i++) begin
            qi.push_back(k);
            qv.push_back(vtab[$urandom_range(0, 7)]);
            k = k + 8'($urandom_range(1, 3));
        end
    endtask

    task automatic set_case1();
        ai = '{8'd1, 8'd4}; av = '{16'h4000, 16'h4200};
        bi = '{8'd1, 8'd4}; bv = '{16'h4200, 16'h4000};
    endtask

    initial begin
        int bound;
        vtab = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h3800, 16'hBC00, 16'hC000, 16'h0000};
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        chk("rst_result", result, 0);
        chk("rst_fpuen",  bus.fpu_clk_en, 0);
        chk("rst_dataa",  bus.fpu_dataa, 0);
        chk("rst_flags",  {overflow, underflow, nan}, 0);
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);

        set_case1();
        run_job("c1", 0);
        chk("c1_spec", res_cap, 16'h4A00);

        ai = '{8'd0}; av = '{16'h3C00};
        bi = '{8'd5}; bv = '{16'h3C00};
        run_job("c2", 0);
        chk("c2_spec", res_cap, 16'h0000);

        ai = '{8'd2, 8'd3, 8'd9}; av = '{16'h4000, 16'h3C00, 16'h3C00};
        bi = '{8'd2};             bv = '{16'h4400};
        run_job("c3", 0);
        chk("c3_spec", res_cap, 16'h4800);

        set_case1();
        run_job("c4", 50);
        chk("c4_spec", res_cap, 16'h4A00);

        ai = '{8'd0}; av = '{16'h7BFF};
        bi = '{8'd0}; bv = '{16'h7BFF};
        run_job("c5", 0);
        repeat (5) @(negedge clk);
        #2;
        chk("c5_ovf_held", overflow, 1);

        // reset during MUL aborts the job
        set_case1();
        prep(0);
        bound = 0;
        while (!(bus.fpu_clk_en && !bus.fpu_op) && bound < 200) begin @(negedge clk); #2; bound++; end
        chk("c6_in_mul", {bus.fpu_clk_en, bus.fpu_op}, 2'b10);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #2;
        chk("c6_busy",   busy, 0);
        chk("c6_done",   done, 0);
        chk("c6_fpuen",  bus.fpu_clk_en, 0);
        chk("c6_data",   {bus.fpu_dataa, bus.fpu_datab}, 0);
        chk("c6_rdy",    {bus.a_ready, bus.b_ready}, 0);
        chk("c6_result", result, 0);
        chk("c6_flags",  {overflow, underflow, nan}, 0);
        drv_en = 1'b0;
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        set_case1();
        run_job("c6_new", 0);
        chk("c6_spec", res_cap, 16'h4A00);

        for (int t = 0; t < 10; t++) begin
            gen_vec(ai, av);
            gen_vec(bi, bv);
            run_job($sformatf("rnd%0d", t), $urandom_range(0, 60));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
